// File: rtl/eth_tx_arbiter.sv
// -----------------------------------------------------------------------------
// eth_tx_arbiter
//
// Purpose:
//   Packet-granular round-robin arbiter sharing the single 64-bit 10G MAC TX
//   AXI-Stream port between NUM_PORTS upstream requesters. A granted port
//   keeps the grant for its whole frame, until its tlast beat is accepted,
//   and the arbiter then re-arbitrates. Arbitration costs one idle cycle per
//   frame. The data path is a purely combinational mux with no added latency.
//   The block also keeps a wrapping per-port count of completed frames.
//
// Parameters:
//   NUM_PORTS  number of upstream requesters (2..8)
//   CNT_W      width of each per-port frame counter
//
// Ports:
//   coreclk           core clock, all logic on its rising edge
//   areset            synchronous, active-high reset
//   s_axis_tdata      per-port data, port i at [i*64 +: 64]
//   s_axis_tkeep      per-port byte enables, port i at [i*8 +: 8]
//   s_axis_tlast      per-port end of frame
//   s_axis_tuser      per-port underrun/abort flag, forwarded to the MAC
//   s_axis_tvalid     per-port valid
//   s_axis_tready     per-port ready (only the granted port can see ready)
//   m_axis_tx_tdata   data to the MAC
//   m_axis_tx_tkeep   byte enables to the MAC
//   m_axis_tx_tlast   end of frame to the MAC
//   m_axis_tx_tuser   underrun/abort flag to the MAC
//   m_axis_tx_tvalid  valid to the MAC
//   m_axis_tx_tready  ready from the MAC
//   grant             one-hot current owner, 0 when idle
//   busy              a frame is in progress
//   frame_cnt         per-port completed-frame counters, port i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module eth_tx_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int CNT_W     = 32
) (
    input  logic                       coreclk,
    input  logic                       areset,
    input  logic [NUM_PORTS*64-1:0]    s_axis_tdata,
    input  logic [NUM_PORTS*8-1:0]     s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]       s_axis_tlast,
    input  logic [NUM_PORTS-1:0]       s_axis_tuser,
    input  logic [NUM_PORTS-1:0]       s_axis_tvalid,
    output logic [NUM_PORTS-1:0]       s_axis_tready,
    output logic [63:0]                m_axis_tx_tdata,
    output logic [7:0]                 m_axis_tx_tkeep,
    output logic                       m_axis_tx_tlast,
    output logic                       m_axis_tx_tuser,
    output logic                       m_axis_tx_tvalid,
    input  logic                       m_axis_tx_tready,
    output logic [NUM_PORTS-1:0]       grant,
    output logic                       busy,
    output logic [NUM_PORTS*CNT_W-1:0] frame_cnt
);

    localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       last_grant_next;
    logic [NUM_PORTS-1:0]   grant_next;
    logic                   busy_next;
    logic [IDX_W-1:0]       grant_idx;
    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic [IDX_W-1:0]       cand_idx;
    int                     rr_cand;
    logic                   frame_done;
    logic [CNT_W-1:0]       cnt [NUM_PORTS];

    // Round-robin pick: scan last_grant+1, last_grant+2, ... (mod NUM_PORTS)
    // and take the first port with tvalid high. The port that owned the
    // previous frame is examined last, so a lone persistent requester still
    // wins every frame.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        rr_cand    = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            rr_cand = int'(last_grant) + k;
            if (rr_cand >= NUM_PORTS) begin
                rr_cand = rr_cand - NUM_PORTS;
            end
            cand_idx = rr_cand[IDX_W-1:0];
            if (!pick_valid && s_axis_tvalid[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Binary index of the one-hot grant, used to record the owner for the
    // next round-robin pass.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    // Combinational data path: the granted port drives the MAC directly and
    // sees the MAC's ready. Nothing is forwarded outside XFER, so the MAC sees
    // tvalid low during the arbitration bubble.
    always_comb begin
        m_axis_tx_tdata  = '0;
        m_axis_tx_tkeep  = '0;
        m_axis_tx_tlast  = 1'b0;
        m_axis_tx_tuser  = 1'b0;
        m_axis_tx_tvalid = 1'b0;
        s_axis_tready    = '0;
        if (state == XFER) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (grant[i]) begin
                    m_axis_tx_tdata  = s_axis_tdata[i*64 +: 64];
                    m_axis_tx_tkeep  = s_axis_tkeep[i*8 +: 8];
                    m_axis_tx_tlast  = s_axis_tlast[i];
                    m_axis_tx_tuser  = s_axis_tuser[i];
                    m_axis_tx_tvalid = s_axis_tvalid[i];
                    s_axis_tready[i] = m_axis_tx_tready;
                end
            end
        end
    end

    // A frame ends when its tlast beat is accepted by the MAC.
    assign frame_done = (state == XFER) && m_axis_tx_tvalid
                        && m_axis_tx_tready && m_axis_tx_tlast;

    // Next-state logic. The grant only changes in IDLE (new owner) or on the
    // accepted tlast beat (release), so a frame is never preempted and a
    // mid-frame tvalid gap keeps the current owner.
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        busy_next       = busy;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next           = '0;
                    grant_next[pick_idx] = 1'b1;
                    busy_next            = 1'b1;
                    state_next           = XFER;
                end
            end
            XFER: begin
                if (frame_done) begin
                    grant_next      = '0;
                    busy_next       = 1'b0;
                    last_grant_next = grant_idx;
                    state_next      = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State register. last_grant resets to the highest port so that port 0
    // is first in line after reset.
    always_ff @(posedge coreclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            busy       <= 1'b0;
            last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            state      <= state_next;
            grant      <= grant_next;
            busy       <= busy_next;
            last_grant <= last_grant_next;
        end
    end

    // Per-port completed-frame counters. They count every completed frame,
    // including ones flagged with tuser, and wrap naturally at 2^CNT_W.
    always_ff @(posedge coreclk) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (areset) begin
                cnt[i] <= '0;
            end else if (frame_done && grant[i]) begin
                cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Flatten the counter array onto the output bus.
    always_comb begin
        frame_cnt = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            frame_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

endmodule
